// File: rtl/class_hvec_search_if.sv
// rtl/class_hvec_search_if.sv - query, generator-select and result signals of the class hypervector search
interface class_hvec_search_if #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2,
    parameter int DIST_W             = 8
);
    logic                          q_valid;
    logic                          q_ready;
    logic [DI_PARALLEL_W_BITS-1:0] q_data;
    logic [CLASS_ID_W-1:0]         frame_id;
    logic [FRAME_IDX_W-1:0]        frame_index;
    logic [DI_PARALLEL_W_BITS-1:0] class_vec_in;
    logic                          res_valid;
    logic                          res_ready;
    logic [CLASS_ID_W-1:0]         res_class;
    logic [DIST_W-1:0]             res_dist;
    logic                          busy;

    modport master (
        output q_valid, q_data, class_vec_in, res_ready,
        input  q_ready, frame_id, frame_index, res_valid, res_class, res_dist, busy
    );

    modport slave (
        input  q_valid, q_data, class_vec_in, res_ready,
        output q_ready, frame_id, frame_index, res_valid, res_class, res_dist, busy
    );
endinterface

// File: rtl/class_hvec_search.sv
// rtl/class_hvec_search.sv - loads a query hypervector, sweeps all classes and reports the nearest by Hamming distance
module class_hvec_search #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2,
    parameter int DIST_W             = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    class_hvec_search_if.slave   bus
);
    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [FRAME_IDX_W-1:0] LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);

    logic [1:0]                    state_q, state_d;
    logic [FRAME_IDX_W-1:0]        beat_q, beat_d;
    logic [FRAME_IDX_W-1:0]        frm_q, frm_d;
    logic [CLASS_ID_W-1:0]         cls_q, cls_d;
    logic [CLASS_ID_W-1:0]         best_cls_q, best_cls_d;
    logic [DIST_W-1:0]             acc_q, acc_d;
    logic [DIST_W-1:0]             best_dist_q, best_dist_d;
    logic [DIST_W-1:0]             acc_sum;
    logic [DI_PARALLEL_W_BITS-1:0] buf_q [NUM_FRAMES];
    logic                          beat_fire;

    function automatic logic [DIST_W-1:0] popcount(input logic [DI_PARALLEL_W_BITS-1:0] v);
        logic [DIST_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            cnt = cnt + DIST_W'(v[i]);
        end
        return cnt;
    endfunction

    assign bus.q_ready     = rst_n & (state_q == S_LOAD);
    assign bus.busy        = (state_q == S_SEARCH);
    assign bus.frame_id    = bus.busy ? cls_q : '0;
    assign bus.frame_index = bus.busy ? frm_q : '0;
    assign bus.res_valid   = (state_q == S_DONE);
    assign bus.res_class   = best_cls_q;
    assign bus.res_dist    = best_dist_q;

    assign beat_fire = bus.q_valid & bus.q_ready;
    assign acc_sum   = acc_q + popcount(buf_q[frm_q] ^ bus.class_vec_in);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        frm_d       = frm_q;
        cls_d       = cls_q;
        acc_d       = acc_q;
        best_cls_d  = best_cls_q;
        best_dist_d = best_dist_q;
        case (state_q)
            S_LOAD: begin
                if (beat_fire) begin
                    if (beat_q == LAST_FRM) begin
                        state_d     = S_SEARCH;
                        beat_d      = '0;
                        frm_d       = '0;
                        cls_d       = '0;
                        acc_d       = '0;
                        best_dist_d = '1;
                        best_cls_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_SEARCH: begin
                if (frm_q == LAST_FRM) begin
                    // strict less-than keeps the lower class index on a tie
                    if (acc_sum < best_dist_q) begin
                        best_dist_d = acc_sum;
                        best_cls_d  = cls_q;
                    end
                    acc_d = '0;
                    frm_d = '0;
                    cls_d = cls_q + 1'b1;
                    if (cls_q == LAST_CLS) begin
                        state_d = S_DONE;
                    end
                end else begin
                    acc_d = acc_sum;
                    frm_d = frm_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            beat_q      <= '0;
            frm_q       <= '0;
            cls_q       <= '0;
            acc_q       <= '0;
            best_cls_q  <= '0;
            best_dist_q <= '0;
            for (int i = 0; i < NUM_FRAMES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            frm_q       <= frm_d;
            cls_q       <= cls_d;
            acc_q       <= acc_d;
            best_cls_q  <= best_cls_d;
            best_dist_q <= best_dist_d;
            if (beat_fire) begin
                buf_q[beat_q] <= bus.q_data;
            end
        end
    end
endmodule

// File: tb/tb_class_hvec_search.sv
// tb/tb_class_hvec_search.sv - self-checking bench for class_hvec_search
module tb_class_hvec_search;
    localparam int W  = 64;
    localparam int NC = 8;
    localparam int NF = 3;
    localparam int CW = 3;
    localparam int FW = 2;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    class_hvec_search_if #(.DI_PARALLEL_W_BITS(W), .CLASS_ID_W(CW), .FRAME_IDX_W(FW), .DIST_W(DW)) bus ();

    class_hvec_search #(
        .DI_PARALLEL_W_BITS(W), .NUM_CLASSES(NC), .NUM_FRAMES(NF),
        .CLASS_ID_W(CW), .FRAME_IDX_W(FW), .DIST_W(DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     errors = 0;
    int     checks = 0;
    bit     stub_mode = 1'b0;
    logic [W-1:0] query [NF];
    int     exp_class = 0;
    int     exp_dist  = 0;
    int     mon_idx   = 0;
    int     last_len  = 0;
    int     lat       = 0;

    // Class hypervector source: pseudo-random frames, or a stub with fixed distances from an all-zero query
    function automatic logic [W-1:0] gen_vec(input int c, input int f, input bit stub);
        logic [W-1:0] v;
        logic [31:0]  k;
        int           n;
        v = '0;
        if (stub) begin
            if (f == 0) begin
                n = (c == 2 || c == 6) ? 10 : 11 + c;
                for (int i = 0; i < n; i++) v[i] = 1'b1;
            end
        end else begin
            k = 32'(c * NF + f + 1);
            v = {k * 32'h9E3779B9, (k * 32'h85EBCA6B) ^ 32'h5BD1E995};
        end
        return v;
    endfunction

    assign bus.class_vec_in = gen_vec(int'(bus.frame_id), int'(bus.frame_index), stub_mode);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_compute();
        int best, best_c, d;
        best   = 1 << 30;
        best_c = 0;
        for (int c = 0; c < NC; c++) begin
            d = 0;
            for (int f = 0; f < NF; f++) d += $countones(query[f] ^ gen_vec(c, f, stub_mode));
            if (d < best) begin
                best   = d;
                best_c = c;
            end
        end
        exp_class = best_c;
        exp_dist  = best;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) begin
                check("frame_id", bus.frame_id, mon_idx / NF);
                check("frame_index", bus.frame_index, mon_idx % NF);
                check("q_ready_in_search", bus.q_ready, 0);
                mon_idx++;
            end else begin
                if (mon_idx != 0) last_len = mon_idx;
                mon_idx = 0;
                check("selects_idle", {bus.frame_id, bus.frame_index}, 0);
            end
            if (bus.res_valid) begin
                check("res_class", bus.res_class, exp_class);
                check("res_dist", bus.res_dist, exp_dist);
                check("q_ready_in_done", bus.q_ready, 0);
            end
        end
    end

    task automatic load_query(input bit rand_gaps);
        int g;
        model_compute();
        for (int f = 0; f < NF; f++) begin
            if (rand_gaps) begin
                bus.q_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            @(negedge clk);
            g = 0;
            while (!bus.q_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("q_ready_wait", int'(g < 50), 1);
            bus.q_valid = 1'b1;
            bus.q_data  = query[f];
            @(posedge clk);
            #1;
            bus.q_valid = 1'b0;
            bus.q_data  = '0;
        end
    endtask

    task automatic wait_result();
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 25);
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("hs_res_valid", bus.res_valid, 0);
        check("hs_q_ready", bus.q_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_ready"}, bus.q_ready, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_class"}, bus.res_class, 0);
        check({tag, "_res_dist"}, bus.res_dist, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_frame_id"}, bus.frame_id, 0);
        check({tag, "_frame_index"}, bus.frame_index, 0);
    endtask

    initial begin
        bus.q_valid   = 1'b0;
        bus.q_data    = '0;
        bus.res_ready = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("q_ready_after_reset", bus.q_ready, 1);

        // exact class-3 query
        for (int f = 0; f < NF; f++) query[f] = gen_vec(3, f, 1'b0);
        load_query(1'b0);
        check("model_exact_class", exp_class, 3);
        check("model_exact_dist", exp_dist, 0);
        wait_result();
        check("exact_class", bus.res_class, 3);
        check("exact_dist", bus.res_dist, 0);
        @(negedge clk);
        #1;
        check("search_len", last_len, 24);
        handshake();

        // class 5 with bits 0, 70, 140 flipped, then long backpressure
        for (int f = 0; f < NF; f++) query[f] = gen_vec(5, f, 1'b0);
        query[0][0]  = ~query[0][0];
        query[1][6]  = ~query[1][6];
        query[2][12] = ~query[2][12];
        load_query(1'b0);
        check("model_flip_class", exp_class, 5);
        check("model_flip_dist", exp_dist, 3);
        wait_result();
        repeat (50) @(posedge clk);
        #1;
        check("bp_res_valid", bus.res_valid, 1);
        check("bp_res_class", bus.res_class, 5);
        check("bp_res_dist", bus.res_dist, 3);
        check("bp_q_ready", bus.q_ready, 0);
        handshake();

        // tie between classes 2 and 6, query beats with random gaps
        stub_mode = 1'b1;
        for (int f = 0; f < NF; f++) query[f] = '0;
        load_query(1'b1);
        check("model_tie_class", exp_class, 2);
        check("model_tie_dist", exp_dist, 10);
        wait_result();
        check("tie_class", bus.res_class, 2);
        check("tie_dist", bus.res_dist, 10);
        @(negedge clk);
        #1;
        check("tie_search_len", last_len, 24);
        handshake();

        // reset in the middle of a search, then a clean reload
        stub_mode = 1'b0;
        for (int f = 0; f < NF; f++) query[f] = gen_vec(3, f, 1'b0);
        load_query(1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("q_ready_after_mid_reset", bus.q_ready, 1);
        load_query(1'b1);
        wait_result();
        check("reload_class", bus.res_class, 3);
        check("reload_dist", bus.res_dist, 0);
        handshake();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
